// File: rtl/vga_pkg.sv
// Shared VGA timing types and stock mode tables used by the raster generator and its axis counters.
package vga_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_mode_t;

   typedef struct packed {
      axis_mode_t h;
      axis_mode_t v;
   } vga_mode_t;

   localparam vga_mode_t MODE_800X600_60 = '{
      h: '{active: 800, fp: 40, sync: 128, bp: 88},
      v: '{active: 600, fp: 1,  sync: 4,   bp: 23}
   };

   localparam vga_mode_t MODE_640X480_60 = '{
      h: '{active: 640, fp: 16, sync: 96, bp: 48},
      v: '{active: 480, fp: 10, sync: 2,  bp: 33}
   };

   localparam int CNT_W_DEF = 11;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus blank/sync flags decoded from the next count so they
// line up with the count register in the same cycle.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 800,
   parameter int FP     = 40,
   parameter int SYNC   = 128,
   parameter int BP     = 88,
   parameter bit POL    = 1'b1,
   parameter int W      = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step,
   input  logic         clear,
   output logic [W-1:0] count,
   output logic         blnk,
   output logic         sync,
   output logic         wrap,
   output logic         active_nxt
);

   localparam logic [W-1:0] LAST       = W'(axis_total(ACTIVE, FP, SYNC, BP) - 1);
   localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

   logic [W-1:0] count_d, count_q;
   logic         blnk_d, blnk_q;
   logic         sync_d, sync_q;

   // Rollover event this cycle; the vertical axis steps on the horizontal one.
   assign wrap = step && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (step) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
      blnk_d = (count_d >= ACT_END);
      sync_d = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : !POL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         blnk_q  <= 1'b0;
         sync_q  <= !POL;
      end else begin
         count_q <= count_d;
         blnk_q  <= blnk_d;
         sync_q  <= sync_d;
      end
   end

   assign active_nxt = !blnk_d;
   assign count      = count_q;
   assign blnk       = blnk_q;
   assign sync       = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; every output is registered and aligned with hcount/vcount.
// Define VGA_TIMING_GEN_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = MODE_800X600_60.h.active,
   parameter int H_FP      = MODE_800X600_60.h.fp,
   parameter int H_SYNC    = MODE_800X600_60.h.sync,
   parameter int H_BP      = MODE_800X600_60.h.bp,
   parameter int V_ACTIVE  = MODE_800X600_60.v.active,
   parameter int V_FP      = MODE_800X600_60.v.fp,
   parameter int V_SYNC    = MODE_800X600_60.v.sync,
   parameter int V_BP      = MODE_800X600_60.v.bp,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             restart,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             de,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   logic clear;
   logic h_wrap, v_wrap;
   logic h_act_nxt, v_act_nxt;
   logic de_d, de_q;
   logic line_start_d, line_start_q;
   logic frame_start_d, frame_start_q;

   // restart is only honoured on an enabled cycle.
   assign clear = restart & ce;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL), .W(CNT_W)
   ) u_h_axis (
      .clk        (pclk),
      .rst_n      (rst_n),
      .step       (ce),
      .clear      (clear),
      .count      (hcount),
      .blnk       (hblnk),
      .sync       (hsync),
      .wrap       (h_wrap),
      .active_nxt (h_act_nxt)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL), .W(CNT_W)
   ) u_v_axis (
      .clk        (pclk),
      .rst_n      (rst_n),
      .step       (h_wrap),
      .clear      (clear),
      .count      (vcount),
      .blnk       (vblnk),
      .sync       (vsync),
      .wrap       (v_wrap),
      .active_nxt (v_act_nxt)
   );

   // The next position is a line/frame origin exactly on restart or on the matching rollover.
   always_comb begin
      de_d          = h_act_nxt & v_act_nxt;
      line_start_d  = ce ? (restart | h_wrap) : line_start_q;
      frame_start_d = ce ? (restart | v_wrap) : frame_start_q;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         de_q          <= 1'b1;
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
      end else begin
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign de          = de_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
   logic [15:0] frame_cnt_d, frame_cnt_q;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (clear) begin
         frame_cnt_d = '0;
      end else if (v_wrap) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 15x10 raster with an active-low vsync.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
   localparam int VA = 6, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
   localparam int W  = 11;

   logic         pclk = 1'b0;
   logic         rst_n, ce, restart;
   logic [W-1:0] hcount, vcount;
   logic         hsync, vsync, hblnk, vblnk, de, line_start, frame_start;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
   logic [15:0]  frame_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int m_h = 0;
   int m_v = 0;

   always #5 pclk = ~pclk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CNT_W(W)
   ) dut (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .ce          (ce),
      .restart     (restart),
      .hcount      (hcount),
      .vcount      (vcount),
      .hsync       (hsync),
      .vsync       (vsync),
      .hblnk       (hblnk),
      .vblnk       (vblnk),
      .de          (de),
      .line_start  (line_start),
      .frame_start (frame_start)
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
      ,
      .frame_cnt   (frame_cnt)
`endif
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // {hsync, vsync, hblnk, vblnk, de, line_start, frame_start}
   function automatic logic [6:0] exp_flags(input int h, input int v);
      logic hs, vs_act, hb, vb;
      hs     = (h >= HA + HF) && (h < HA + HF + HS);
      vs_act = (v >= VA + VF) && (v < VA + VF + VS);
      hb     = (h >= HA);
      vb     = (v >= VA);
      return {hs, ~vs_act, hb, vb, ~hb & ~vb, h == 0, (h == 0) && (v == 0)};
   endfunction

   function automatic logic [6:0] obs_flags();
      return {hsync, vsync, hblnk, vblnk, de, line_start, frame_start};
   endfunction

   task automatic check_model(input string tag);
      check_val({tag, "_h"}, int'(hcount), m_h);
      check_val({tag, "_v"}, int'(vcount), m_v);
      check_val({tag, "_flags"}, int'(obs_flags()), int'(exp_flags(m_h, m_v)));
   endtask

   task automatic tick(input logic c);
      ce = c;
      @(posedge pclk);
      #1;
      if (c) begin
         if (restart) begin
            m_h = 0;
            m_v = 0;
         end else if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
         end else begin
            m_h++;
         end
      end
   endtask

   task automatic run_to(input int h, input int v);
      int found;
      found = 0;
      for (int i = 0; i < HT * VT + 2 && found == 0; i++) begin
         if (int'(hcount) == h && int'(vcount) == v) found = 1;
         else tick(1'b1);
      end
      check_val($sformatf("reach_%0d_%0d", h, v), found, 1);
   endtask

   typedef struct {
      int         h;
      int         v;
      logic [6:0] flags;
   } probe_t;

   probe_t probes[10] = '{
      '{7,  0, 7'b0100100},
      '{8,  0, 7'b0110000},
      '{10, 0, 7'b1110000},
      '{12, 0, 7'b1110000},
      '{13, 0, 7'b0110000},
      '{0,  6, 7'b0101010},
      '{14, 6, 7'b0111000},
      '{0,  7, 7'b0001010},
      '{14, 8, 7'b0011000},
      '{0,  9, 7'b0101010}
   };

   initial begin
      int n_ls, n_fs;
      rst_n   = 1'b0;
      ce      = 1'b0;
      restart = 1'b0;
      #12;
      check_val("rst_h", int'(hcount), 0);
      check_val("rst_v", int'(vcount), 0);
      check_val("rst_flags", int'(obs_flags()), int'(7'b0100111));
      $display("reset: h=%0d v=%0d flags=%b", hcount, vcount, obs_flags());

      @(negedge pclk);
      rst_n = 1'b1;

      n_ls = 0;
      n_fs = 0;
      for (int k = 0; k < HT * VT; k++) begin
         check_model("sweep");
         if (line_start) n_ls++;
         if (frame_start) n_fs++;
         tick(1'b1);
      end
      check_val("sweep_line_starts", n_ls, VT);
      check_val("sweep_frame_starts", n_fs, 1);
      check_val("wrap_h", int'(hcount), 0);
      check_val("wrap_v", int'(vcount), 0);
      $display("full frame: line_start=%0d frame_start=%0d", n_ls, n_fs);

      foreach (probes[i]) begin
         run_to(probes[i].h, probes[i].v);
         check_val($sformatf("probe_%0d_%0d", probes[i].h, probes[i].v),
                   int'(obs_flags()), int'(probes[i].flags));
         $display("probe (%0d,%0d): flags=%b", probes[i].h, probes[i].v, obs_flags());
      end

      for (int k = 0; k < 300; k++) begin
         tick(1'($urandom_range(0, 1)));
         check_model("gated");
      end
      $display("gated run: now at (%0d,%0d)", hcount, vcount);

      run_to(5, 3);
      restart = 1'b1;
      tick(1'b0);
      check_val("restart_noce_h", int'(hcount), 5);
      check_val("restart_noce_v", int'(vcount), 3);
      tick(1'b1);
      restart = 1'b0;
      check_val("restart_h", int'(hcount), 0);
      check_val("restart_v", int'(vcount), 0);
      check_val("restart_fs", int'(frame_start), 1);
      check_model("restart");
      $display("restart at (5,3): now (%0d,%0d) frame_start=%0d", hcount, vcount, frame_start);

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
      check_val("fcnt_after_restart", int'(frame_cnt), 0);
      for (int k = 0; k < 3 * HT * VT; k++) tick(1'b1);
      check_val("fcnt_3_frames", int'(frame_cnt), 3);
      restart = 1'b1;
      tick(1'b1);
      restart = 1'b0;
      check_val("fcnt_cleared", int'(frame_cnt), 0);
      $display("frame_cnt: 3 frames counted, restart cleared to %0d", frame_cnt);
`endif

      run_to(9, 7);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_h", int'(hcount), 0);
      check_val("async_rst_v", int'(vcount), 0);
      check_val("async_rst_flags", int'(obs_flags()), int'(7'b0100111));
      m_h = 0;
      m_v = 0;
      @(negedge pclk);
      rst_n = 1'b1;
      tick(1'b1);
      check_val("post_rst_h", int'(hcount), 1);
      check_model("post_rst");
      $display("async reset at (9,7): resumed at (%0d,%0d)", hcount, vcount);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator.
- Produces horizontal/vertical counters, sync, blanking, data-enable and line/frame strobes for any mode set by parameters.
- Sits between the pixel clock domain and the drawing pipeline; all downstream draw blocks consume its counters and strobes.
- Defaults give 800x600@60 Hz (40 MHz pclk).

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, active level of hsync (1 = positive)
- VSYNC_POL, 1, active level of vsync
- CNT_W, 11, counter width; must satisfy 2^CNT_W > max(H_TOTAL, V_TOTAL)

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock enable; when low, all state holds
- restart  in  1  synchronous request to restart the raster at pixel (0,0)
- hcount  out  CNT_W  current pixel column
- vcount  out  CNT_W  current line
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- hblnk  out  1  high outside the horizontal active region
- vblnk  out  1  high outside the vertical active region
- de  out  1  data enable = !hblnk & !vblnk
- line_start  out  1  one-cycle strobe while hcount==0
- frame_start  out  1  one-cycle strobe while hcount==0 and vcount==0

Behaviour:
- Interface: one clock (pclk); reset rst_n is asynchronous, active-low.
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- All outputs are registered. Every decoded output is consistent with the hcount/vcount presented in the same cycle: next-state decode, zero skew, no one-cycle lag.
- Reset values: hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=!HSYNC_POL, vsync=!VSYNC_POL, line_start=1, frame_start=1.
- Counting, on each pclk edge with ce=1:
  - hcount increments, wrapping from H_TOTAL-1 to 0.
  - vcount increments only when hcount wraps, wrapping from V_TOTAL-1 to 0.
- Decode:
  - hblnk = hcount >= H_ACTIVE.
  - hsync active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 840..967).
  - vblnk = vcount >= V_ACTIVE.
  - vsync active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 601..604).
- vsync transitions coincide with hcount==0 of the affected line.
- ce=0: all registers, including strobes, hold. Strobes therefore stretch over gated cycles; consumers qualify them with ce.
- restart=1 with ce=1: next state equals the reset state. restart has priority over normal increment.
- restart=1 with ce=0: ignored.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). Counting resumes from (0,0) on the first edge after deassertion.
- Counter arithmetic is done in CNT_W bits; the comparisons never rely on overflow.

Optional Feature:
- Macro VGA_TIMING_GEN_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt [15:0]. Reset value is 0.
  - frame_cnt increments, with natural 16-bit wrap, on the cycle the raster wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - restart clears frame_cnt to 0.
- When undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - default mode constants for 800x600@60 and 640x480@60;
  - a mode struct/typedef (active, fp, sync, bp per axis);
  - the CNT_W default.
- One natural sub-module: vga_axis_counter, instantiated twice (horizontal, vertical).
  - Parameters: ACTIVE/FP/SYNC/BP/POL/W.
  - Inputs: step, clear.
  - Outputs: count, blnk, sync, wrap.
  - Horizontal step = ce. Vertical step = ce & hwrap.

Test Plan:
- Reset then run 1056*628 cycles, defaults -> hcount wraps 1055->0; vcount wraps 627->0; exactly 1 frame_start and 628 line_start pulses.
- Probe line 0 -> hblnk rises at hcount=800; hsync high exactly at hcount 840..967 (128 cycles); de high for hcount 0..799.
- Probe frame -> vblnk high for vcount 600..627; vsync high for vcount 601..604, changing on hcount==0; HSYNC_POL=0 build gives inverted hsync.
- Toggle ce with 50% random gaps -> hcount/vcount sequence identical to the ungated run; outputs frozen while ce=0.
- Pulse restart at (500,300) with ce=1 -> next cycle (0,0), frame_start=1; rst_n low at (900,610) -> immediate reset values without a clock edge.
- With VGA_TIMING_GEN_FRAME_CNT_EN -> frame_cnt=3 after 3 full frames; 0xFFFF wraps to 0; restart clears it.
